// File: rtl/xout_change_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xout_change_fifo_pkg
//  Description : Shared constants and helpers for the XOUT change-log FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package xout_change_fifo_pkg;

    // Name of the reusable storage sub-module instantiated by the top level.
    localparam string FIFO_SUB_NAME = "xout_change_fifo_sync_fifo";

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int calc_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xout_change_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xout_change_fifo_sync_fifo
//  Description : Show-ahead synchronous FIFO with a registered head value.
//                Full/empty come from the occupancy counter; a push into a
//                full FIFO is only taken when a pop frees a slot in the
//                same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module xout_change_fifo_sync_fifo
    import xout_change_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = calc_cw(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic [CW-1:0]    COUNT,
    output logic             FULL
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic [WIDTH-1:0] w_head_next;

    // Handshake qualification, next occupancy and next head value.
    always_comb begin
        w_full        = (r_count == CW'(DEPTH));
        w_empty       = (r_count == CW'(0));
        w_pop         = POP && !w_empty;
        w_push        = PUSH && (!w_full || w_pop);
        w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase

        // The head register holds its last value once the FIFO drains.
        // When the next head slot is the one being written this cycle, the
        // incoming word is forwarded into the head register (visible next
        // cycle, never combinationally).
        w_head_next = r_head;
        if (w_count_next != CW'(0)) begin
            if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
                w_head_next = DIN;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    // Storage array write port; no reset needed, contents are never observed
    // before being written.
    always_ff @(posedge CLK) begin
        if (RESET && w_push) begin
            r_mem[r_wr_ptr] <= DIN;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
        end
    end

    assign DOUT   = r_head;
    assign DVALID = !w_empty;
    assign COUNT  = r_count;
    assign FULL   = w_full;

endmodule
`default_nettype wire

// File: rtl/xout_change_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xout_change_fifo
//  Description : Logs value transitions of the upstream XOUT stream. A sample
//                is queued only when it differs from the previous enabled
//                sample (or is the first after EN rises). Dropped changes
//                raise a sticky OVERFLOW flag.
//  Revision    : 1.0  initial release
// ============================================================================
module xout_change_fifo
    import xout_change_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = calc_cw(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] XIN,
    input  logic             DREADY,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic [CW-1:0]    COUNT,
    output logic             OVERFLOW
);

    logic [WIDTH-1:0] r_prev;
    logic             r_prev_valid;
    logic             r_overflow;

    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

    // Change detection and push acceptance against the current occupancy.
    always_comb begin
        w_push_req = EN && (!r_prev_valid || (XIN != r_prev));
        w_pop      = DVALID && DREADY;
        w_push     = w_push_req && (!w_full || w_pop);
    end

    // Previous-sample tracker; EN low invalidates it so the next enabled
    // sample is always logged.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (EN) begin
            r_prev       <= XIN;
            r_prev_valid <= 1'b1;
        end else begin
            r_prev_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
        end else if (CLR_OVF) begin
            r_overflow <= 1'b0;
        end
    end

    xout_change_fifo_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK    (CLK),
        .RESET  (RESET),
        .PUSH   (w_push),
        .POP    (w_pop),
        .DIN    (XIN),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .COUNT  (COUNT),
        .FULL   (w_full)
    );

    assign OVERFLOW = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_xout_change_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xout_change_fifo
//  Description : Scoreboard bench for xout_change_fifo with a queue-based
//                reference model and randomized plus directed stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xout_change_fifo;
    import xout_change_fifo_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = calc_cw(DEPTH);

    logic             CLK;
    logic             RESET;
    logic             EN;
    logic [WIDTH-1:0] XIN;
    logic             DREADY;
    logic             CLR_OVF;
    logic [WIDTH-1:0] DOUT;
    logic             DVALID;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;

    xout_change_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .XIN      (XIN),
        .DREADY   (DREADY),
        .CLR_OVF  (CLR_OVF),
        .DOUT     (DOUT),
        .DVALID   (DVALID),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the FIFO as a queue plus the change-detect state.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] expq[$];
    logic [WIDTH-1:0] m_prev = '0;
    logic [WIDTH-1:0] m_head = '0;
    bit               m_pv   = 1'b0;
    bit               m_ovf  = 1'b0;
    logic [WIDTH-1:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, then check state.
    task automatic cycle(input logic rst, input logic en, input logic [WIDTH-1:0] xin,
                         input logic drdy, input logic clr);
        bit pop, preq, push;
        RESET = rst; EN = en; XIN = xin; DREADY = drdy; CLR_OVF = clr;
        if (!rst) begin
            mq.delete();
            m_prev = '0; m_pv = 1'b0; m_ovf = 1'b0; m_head = '0;
        end else begin
            pop  = (mq.size() != 0) && drdy;
            preq = en && (!m_pv || (xin != m_prev));
            push = preq && ((mq.size() < DEPTH) || pop);
            if (pop)  expq.push_back(mq.pop_front());
            if (push) mq.push_back(xin);
            if (preq && !push) m_ovf = 1'b1;
            else if (clr)      m_ovf = 1'b0;
            if (en) begin m_prev = xin; m_pv = 1'b1; end
            else    m_pv = 1'b0;
            if (mq.size() != 0) m_head = mq[0];
        end
        @(posedge CLK);
        #1;
        chk("count",    32'(COUNT),    32'(mq.size()));
        chk("dvalid",   32'(DVALID),   32'(mq.size() != 0));
        chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
        if (mq.size() == 0) chk("dout_hold", 32'(DOUT), 32'(m_head));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: every accepted transfer must match the scoreboard head.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && DVALID === 1'b1 && DREADY === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got %0h expected nothing at %0t", DOUT, $time);
            end else begin
                mon_exp = expq.pop_front();
                chk("dout_order", 32'(DOUT), 32'(mon_exp));
            end
        end
    end

    initial begin
        $display("tb: storage sub-module %s, CW=%0d", FIFO_SUB_NAME, CW);

        // Reset and hold with active inputs.
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("reset_count", 32'(COUNT), 32'd0);
        chk("reset_dout",  32'(DOUT),  32'd0);

        // Change filtering.
        cycle(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd7, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd7, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
        chk("filter_count", 32'(COUNT), 32'd3);
        drain(4);
        chk("filter_drained", 32'(DVALID), 32'd0);
        chk("filter_dout_hold", 32'(DOUT), 32'd9);

        // EN re-arm: a repeated value is logged again after EN low.
        cycle(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        chk("rearm_count", 32'(COUNT), 32'd2);
        drain(3);

        // Overflow, clear, and set-beats-clear.
        for (int i = 0; i <= 8; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        chk("ovf_count", 32'(COUNT),    32'd8);
        chk("ovf_set",   32'(OVERFLOW), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", 32'(OVERFLOW), 32'd0);
        cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(OVERFLOW), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        drain(9);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pp_count", 32'(COUNT),    32'd8);
        chk("full_pp_ovf",   32'(OVERFLOW), 32'd0);
        drain(9);
        chk("full_pp_last", 32'(DOUT), 32'hAA);

        // Streaming with toggling ready, reset in the middle.
        for (int i = 0; i < 20; i++) begin
            if (i == 12) begin
                cycle(1'b0, 1'b1, 8'(i * 7 + 1), 1'(i % 2), 1'b0);
                chk("mid_reset_count",  32'(COUNT),  32'd0);
                chk("mid_reset_dvalid", 32'(DVALID), 32'd0);
                chk("mid_reset_dout",   32'(DOUT),   32'd0);
            end else if (i == 13) begin
                cycle(1'b1, 1'b1, 8'h00, 1'(i % 2), 1'b0);
                chk("post_reset_capture", 32'(COUNT), 32'd1);
            end else begin
                cycle(1'b1, 1'b1, 8'(i * 7 + 1), 1'(i % 2), 1'b0);
            end
        end
        drain(10);

        // Randomized traffic with small value alphabet to force repeats.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) != 0),
                  1'($urandom_range(0, 9) != 0),
                  8'($urandom_range(0, 3)),
                  1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 19) == 0));
        end
        drain(12);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
